video_tft_timing: RTL and testbench

//   TFT panel timing generator and pixel output stage clocked by TFTCLK from Video_ClockManager.

---
 rtl/video_tft_timing.sv | 133 +++++++++++++
 tb/tb_video_tft_timing.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/video_tft_timing.sv
// TFT panel timing generator: IDLE/RUN sequencer, h/v counters, pixel request,
// and a one-stage registered output to the panel with sticky underflow detection.
module video_tft_timing #(
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned H_FP     = 2,
  parameter int unsigned H_SYNC   = 41,
  parameter int unsigned H_BP     = 2,
  parameter int unsigned V_ACTIVE = 272,
  parameter int unsigned V_FP     = 2,
  parameter int unsigned V_SYNC   = 10,
  parameter int unsigned V_BP     = 2,
  parameter int unsigned CW       = 10
) (
  input  logic          TFTCLK,
  input  logic          Reset_n,
  input  logic          Enable,
  input  logic [15:0]   PixelData,
  input  logic          PixelValid,
  output logic          PixelReq,
  output logic [CW-1:0] PixelX,
  output logic [CW-1:0] PixelY,
  output logic          FrameStart,
  input  logic          ClearUnderflow,
  output logic          Underflow,
  output logic          TFT_HSYNC,
  output logic          TFT_VSYNC,
  output logic          TFT_DE,
  output logic [15:0]   TFT_RGB
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_S = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_E = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_S = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_E = CW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          req;
  logic          hs0;
  logic          vs0;
  logic          fs;

  // Sequencer state and raster counters
  always_ff @(posedge TFTCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  // Next state, counter advance and stage-0 timing decode; stop only at frame end
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    req     = 1'b0;
    hs0     = 1'b1;
    vs0     = 1'b1;
    fs      = 1'b0;
    case (state_q)
      IDLE: begin
        h_d = '0;
        v_d = '0;
        if (Enable) state_d = RUN;
      end
      RUN: begin
        req = (h_q < H_ACT) && (v_q < V_ACT);
        hs0 = !((h_q >= H_SYNC_S) && (h_q < H_SYNC_E));
        vs0 = !((v_q >= V_SYNC_S) && (v_q < V_SYNC_E));
        fs  = (h_q == '0) && (v_q == '0);
        if (h_q == H_LAST) begin
          h_d = '0;
          if (v_q == V_LAST) begin
            v_d = '0;
            if (!Enable) state_d = IDLE;
          end else begin
            v_d = v_q + CW'(1);
          end
        end else begin
          h_d = h_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign PixelReq   = req;
  assign PixelX     = h_q;
  assign PixelY     = v_q;
  assign FrameStart = fs;

  // Panel output stage: syncs, DE and pixel aligned one clock after the request
  always_ff @(posedge TFTCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      TFT_HSYNC <= 1'b1;
      TFT_VSYNC <= 1'b1;
      TFT_DE    <= 1'b0;
      TFT_RGB   <= 16'h0000;
    end else begin
      TFT_HSYNC <= hs0;
      TFT_VSYNC <= vs0;
      TFT_DE    <= req;
      TFT_RGB   <= (req && PixelValid) ? PixelData : 16'h0000;
    end
  end

  // Sticky underflow; a new underflow beats a simultaneous clear
  always_ff @(posedge TFTCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      Underflow <= 1'b0;
    end else if (req && !PixelValid) begin
      Underflow <= 1'b1;
    end else if (ClearUnderflow) begin
      Underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_tft_timing.sv
// Bench for video_tft_timing in the small 8x6 raster configuration.
module tb_video_tft_timing;

  logic        clk = 1'b0;
  logic        clk_on = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] pixel_data = 16'h0000;
  logic        pixel_valid = 1'b0;
  logic        clear_underflow = 1'b0;
  logic        pixel_req;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        frame_start;
  logic        underflow;
  logic        tft_hsync;
  logic        tft_vsync;
  logic        tft_de;
  logic [15:0] tft_rgb;

  video_tft_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CW(10)
  ) dut (
    .TFTCLK(clk),
    .Reset_n(rst_n),
    .Enable(enable),
    .PixelData(pixel_data),
    .PixelValid(pixel_valid),
    .PixelReq(pixel_req),
    .PixelX(pixel_x),
    .PixelY(pixel_y),
    .FrameStart(frame_start),
    .ClearUnderflow(clear_underflow),
    .Underflow(underflow),
    .TFT_HSYNC(tft_hsync),
    .TFT_VSYNC(tft_vsync),
    .TFT_DE(tft_de),
    .TFT_RGB(tft_rgb)
  );

  always #5 if (clk_on) clk = ~clk;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [15:0] rgb;
  } panel_t;

  typedef struct {
    int cycles;
    bit en;
    bit drop;
    int clr_mode;  // 0 none, 1 at the drop pixel, 2 on the first cycle
    int exp_req;
    int exp_fs;
  } phase_t;

  panel_t sb_q[$];
  int     n_checks = 0;
  int     n_pass = 0;

  // Reference model: running flag, cycle index within the 48-clock frame, underflow
  bit m_run = 1'b0;
  int m_t = 0;
  bit m_uf = 1'b0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input bit en, input bit drop, input int clr_mode, input bit first,
                      output bit got_req, output bit got_fs);
    int     mh, mv;
    bit     ereq, ehs, evs, efs, val, clr;
    panel_t e, g;
    mh   = m_run ? (m_t % 8) : 0;
    mv   = m_run ? (m_t / 8) : 0;
    ereq = m_run && (mh < 4) && (mv < 3);
    ehs  = !(m_run && (mh >= 5) && (mh < 7));
    evs  = !(m_run && (mv == 4));
    efs  = m_run && (m_t == 0);
    val  = !(drop && mh == 2 && mv == 1);
    clr  = (clr_mode == 1 && mh == 2 && mv == 1) || (clr_mode == 2 && first);
    enable          = en;
    pixel_valid     = val;
    pixel_data      = {8'(mv), 8'(mh)};
    clear_underflow = clr;
    chk("pixel_req", pixel_req, ereq);
    chk("pixel_x", pixel_x, mh);
    chk("pixel_y", pixel_y, mv);
    chk("frame_start", frame_start, efs);
    got_req = pixel_req;
    got_fs  = frame_start;
    e.de  = ereq;
    e.hs  = ehs;
    e.vs  = evs;
    e.rgb = (ereq && val) ? {8'(mv), 8'(mh)} : 16'h0000;
    sb_q.push_back(e);
    if (ereq && !val) m_uf = 1'b1;
    else if (clr) m_uf = 1'b0;
    if (!m_run) begin
      if (en) begin m_run = 1'b1; m_t = 0; end
    end else if (m_t == 47) begin
      m_t = 0;
      if (!en) m_run = 1'b0;
    end else begin
      m_t++;
    end
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      g = sb_q.pop_front();
      chk("tft_de", tft_de, g.de);
      chk("tft_hsync", tft_hsync, g.hs);
      chk("tft_vsync", tft_vsync, g.vs);
      chk("tft_rgb", tft_rgb, g.rgb);
    end
    chk("underflow", underflow, m_uf);
  endtask

  task automatic run_phase(input phase_t p, input int idx);
    int n_req, n_fs;
    bit r, f;
    n_req = 0;
    n_fs  = 0;
    for (int i = 0; i < p.cycles; i++) begin
      tick(p.en, p.drop, p.clr_mode, i == 0, r, f);
      n_req += int'(r);
      n_fs  += int'(f);
    end
    chk($sformatf("phase%0d_req_count", idx), n_req, p.exp_req);
    chk($sformatf("phase%0d_fs_count", idx), n_fs, p.exp_fs);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hsync"}, tft_hsync, 1);
    chk({tag, "_vsync"}, tft_vsync, 1);
    chk({tag, "_de"}, tft_de, 0);
    chk({tag, "_rgb"}, tft_rgb, 0);
    chk({tag, "_underflow"}, underflow, 0);
    chk({tag, "_pixel_req"}, pixel_req, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_pixel_x"}, pixel_x, 0);
    chk({tag, "_pixel_y"}, pixel_y, 0);
  endtask

  phase_t phases[12];
  phase_t restart;

  initial begin
    phases[0]  = '{100, 1'b0, 1'b0, 0, 0, 0};   // idle hold
    phases[1]  = '{1,   1'b1, 1'b0, 0, 0, 0};   // enable seen in IDLE
    phases[2]  = '{96,  1'b1, 1'b0, 0, 24, 2};  // two clean frames
    phases[3]  = '{48,  1'b1, 1'b1, 0, 12, 1};  // underflow at (2,1)
    phases[4]  = '{48,  1'b1, 1'b1, 1, 12, 1};  // clear coincides with underflow
    phases[5]  = '{1,   1'b1, 1'b0, 2, 1, 1};   // clear alone
    phases[6]  = '{47,  1'b1, 1'b0, 0, 11, 0};
    phases[7]  = '{9,   1'b1, 1'b0, 0, 5, 1};   // up to h=1, v=1
    phases[8]  = '{39,  1'b0, 1'b0, 0, 7, 0};   // enable dropped, frame completes
    phases[9]  = '{20,  1'b0, 1'b0, 0, 0, 0};   // idle
    phases[10] = '{1,   1'b1, 1'b0, 0, 0, 0};   // re-raise enable
    phases[11] = '{19,  1'b1, 1'b1, 0, 11, 1};  // up to h=3, v=2 with underflow set
    restart    = '{49,  1'b1, 1'b0, 0, 12, 1};

    // Reset with no clock running
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("reset");
    #1 rst_n = 1'b1;
    clk_on = 1'b1;

    for (int i = 0; i < 12; i++) run_phase(phases[i], i);
    chk("pre_reset_underflow", underflow, 1);

    // Asynchronous reset between edges at h=3, v=2
    enable = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    m_run = 1'b0;
    m_t   = 0;
    m_uf  = 1'b0;
    #2 rst_n = 1'b1;
    run_phase(restart, 12);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
